cve2_sleep_ctrl: RTL and testbench
==================================

Name: cve2_sleep_ctrl

Overview:
Parametrised core sleep/clock-gate controller that replaces the fixed enable logic in the CVE2 top level.
- Latches fetch enable and tracks core activity.
- Waits a configurable idle hold time before gating.
- Wakes on debug, NMI, pending interrupt, or any of N maskable wake sources.
- Drives the enable of the existing cve2_clock_gate and the core_sleep_o status.

Parameters:
NumWakeSrc, 4, number of external wake request lines (>=1).
IdleHoldCycles, 0, extra consecutive idle cycles required before sleep; 0 gives the legacy single-cycle behaviour.
StatsWidth, 32, width of the sleep statistics counters (used only with CVE2_SLEEP_STATS_EN).

Ports:
clk_i  in  1  ungated core clock.
rst_ni  in  1  asynchronous active-low reset.
fetch_enable_i  in  1  fetch enable request; sticky once seen high.
core_busy_i  in  1  core busy indication, sampled every clk_i edge.
debug_req_i  in  1  debug request (wake source).
irq_nm_i  in  1  non-maskable interrupt (wake source).
irq_pending_i  in  1  core pending-interrupt flag (wake source).
wake_i  in  NumWakeSrc  external wake requests, level sensitive.
wake_mask_i  in  NumWakeSrc  per-source enable; 1 = source may wake.
fetch_enable_o  out  1  registered sticky fetch enable to the core.
clock_en_o  out  1  enable for cve2_clock_gate.
core_sleep_o  out  1  core is gated and no wake is present.
sleep_cycles_o  out  StatsWidth  saturating count of cycles with core_sleep_o=1 (macro only).
sleep_entries_o  out  StatsWidth  saturating count of SLEEP entries (macro only).
stats_clr_i  in  1  synchronous clear of both statistics counters (macro only).

Behaviour:
- Single clock clk_i; reset rst_ni is asynchronous, active-low.
- All state is reset to: state=OFF, fetch_en_q=0, hold counter=0, stats=0.
- Reset values of outputs: fetch_enable_o=0, clock_en_o=0, core_sleep_o=0.
- Definitions:
  - wake = debug_req_i | irq_nm_i | irq_pending_i | |(wake_i & wake_mask_i)
  - idle = !core_busy_i & !wake
- fetch_en_q: set on the first clk_i edge with fetch_enable_i=1; cleared only by reset. fetch_enable_o = fetch_en_q.
- FSM states: OFF, RUN, DRAIN, SLEEP.
  - OFF: clock_en_o=0, core_sleep_o=0. Goes to RUN on the edge where fetch_enable_i=1.
  - RUN: clock_en_o=1. On an idle sample: IdleHoldCycles==0 goes to SLEEP, otherwise goes to DRAIN with cnt=IdleHoldCycles-1. Otherwise stays in RUN.
  - DRAIN: clock_en_o=1. A non-idle sample (busy or wake) goes to RUN. Otherwise cnt==0 goes to SLEEP, else cnt decrements.
  - SLEEP: clock_en_o=wake (combinational, so the clock runs in the same cycle wake rises). core_sleep_o=!wake. wake=1 goes to RUN at the next edge. core_busy_i is ignored in SLEEP.
- Sleep entry requires exactly IdleHoldCycles+1 consecutive idle samples.
- Wake latency: zero cycles to clock_en_o=1.
- Simultaneous events:
  - wake has priority over idle in every state.
  - busy and wake together keep RUN.
  - A wake pulse of one cycle in SLEEP is sufficient; the FSM re-enters RUN.
- Hold counter width is max(1, $clog2(IdleHoldCycles+1)).
- Reset mid-operation (any state) returns immediately to OFF with clock_en_o=0; fetch enable must be re-asserted.
- Masked wake sources (mask=0) have no effect in any state.
- fetch_enable_i deassertion after latching has no effect.

Optional Feature:
Macro CVE2_SLEEP_STATS_EN.
- Defined:
  - sleep_cycles_o increments each cycle core_sleep_o=1.
  - sleep_entries_o increments on each transition into SLEEP.
  - Both saturate at all-ones.
  - stats_clr_i=1 zeroes both and has priority over increment in the same cycle.
- Not defined: the three stats ports are absent and no counter flops exist.

Decomposition:
- cve2_pkg holds sleep_state_e (OFF, RUN, DRAIN, SLEEP; 2-bit encoding).
- No sub-module is required. The saturating counter is a natural small sub-module cve2_sat_counter (Width, inc_i, clr_i, cnt_o), instantiated twice under the macro.
- cve2_clock_gate stays instantiated in cve2_top.

Test Plan:
- Reset, then fetch_enable_i=1 for 1 cycle with core_busy_i=1 -> fetch_enable_o=1 and clock_en_o=1 from the next cycle; fetch_enable_i=0 afterwards keeps both at 1.
- IdleHoldCycles=3, busy drops at edge k with no wake -> clock_en_o stays 1 through the cycle after edge k+3 and falls after edge k+4 (4 idle samples); core_sleep_o=1.
- IdleHoldCycles=3, busy low for 2 cycles then high for 1 -> returns to RUN; a full 4 idle samples are required again before sleep.
- In SLEEP, wake_i=4'b0100, wake_mask_i=4'b1011 -> no wake; then mask=4'b1111 -> clock_en_o=1 in the same cycle, RUN next edge.
- In SLEEP, irq_nm_i pulses 1 cycle -> clock_en_o=1 that cycle, state RUN, core_sleep_o=0; debug_req_i together with core_busy_i=0 in RUN -> no DRAIN entry.
- With CVE2_SLEEP_STATS_EN, 2 sleep episodes of 5 and 7 cycles -> sleep_entries_o=2, sleep_cycles_o=12; StatsWidth=3 with 10 sleep cycles -> 7 (saturated); stats_clr_i with an increment in the same cycle -> 0.

Source files
------------

// File: rtl/cve2_pkg.sv
// Shared types for the CVE2 sleep controller.
// Optional statistics are built in only when CVE2_SLEEP_STATS_EN is defined.
package cve2_pkg;

  typedef enum logic [1:0] {
    SLP_OFF   = 2'b00,
    SLP_RUN   = 2'b01,
    SLP_DRAIN = 2'b10,
    SLP_SLEEP = 2'b11
  } sleep_state_e;

endpackage

// File: rtl/cve2_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Instantiated by cve2_sleep_ctrl only when CVE2_SLEEP_STATS_EN is defined.
module cve2_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cve2_sleep_ctrl.sv
// Core sleep / clock-gate enable controller with idle hold time.
// Define CVE2_SLEEP_STATS_EN to add sleep cycle/entry statistics.
module cve2_sleep_ctrl
  import cve2_pkg::*;
#(
  parameter int unsigned NumWakeSrc     = 4,
  parameter int unsigned IdleHoldCycles = 0,
  parameter int unsigned StatsWidth     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_enable_i,
  input  logic                  core_busy_i,
  input  logic                  debug_req_i,
  input  logic                  irq_nm_i,
  input  logic                  irq_pending_i,
  input  logic [NumWakeSrc-1:0] wake_i,
  input  logic [NumWakeSrc-1:0] wake_mask_i,
  output logic                  fetch_enable_o,
  output logic                  clock_en_o,
  output logic                  core_sleep_o
`ifdef CVE2_SLEEP_STATS_EN
  ,
  input  logic                  stats_clr_i,
  output logic [StatsWidth-1:0] sleep_cycles_o,
  output logic [StatsWidth-1:0] sleep_entries_o
`endif
);

  localparam int unsigned CntW =
    (IdleHoldCycles > 0) ? $clog2(IdleHoldCycles + 1) : 1;
  localparam logic [CntW-1:0] HoldInit =
    CntW'((IdleHoldCycles > 0) ? IdleHoldCycles - 1 : 0);

  sleep_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fetch_en_q;
  logic            wake;
  logic            idle;

  assign wake = debug_req_i | irq_nm_i | irq_pending_i |
                (|(wake_i & wake_mask_i));
  assign idle = ~core_busy_i & ~wake;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SLP_OFF;
      cnt_q      <= '0;
      fetch_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fetch_en_q <= fetch_en_q | fetch_enable_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clock_en_o   = 1'b0;
    core_sleep_o = 1'b0;
    unique case (state_q)
      SLP_OFF: begin
        if (fetch_enable_i) state_d = SLP_RUN;
      end
      SLP_RUN: begin
        clock_en_o = 1'b1;
        if (idle) begin
          if (IdleHoldCycles == 0) begin
            state_d = SLP_SLEEP;
          end else begin
            state_d = SLP_DRAIN;
            cnt_d   = HoldInit;
          end
        end
      end
      SLP_DRAIN: begin
        clock_en_o = 1'b1;
        if (!idle) begin
          state_d = SLP_RUN;
        end else if (cnt_q == '0) begin
          state_d = SLP_SLEEP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      SLP_SLEEP: begin
        // Combinational so the clock restarts in the cycle wake rises
        clock_en_o   = wake;
        core_sleep_o = ~wake;
        if (wake) state_d = SLP_RUN;
      end
      default: state_d = SLP_OFF;
    endcase
  end

  assign fetch_enable_o = fetch_en_q;

`ifdef CVE2_SLEEP_STATS_EN
  logic sleep_entry;

  assign sleep_entry = (state_d == SLP_SLEEP) && (state_q != SLP_SLEEP);

  cve2_sat_counter #(
    .Width(StatsWidth)
  ) u_sleep_cycles (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (core_sleep_o),
    .clr_i (stats_clr_i),
    .cnt_o (sleep_cycles_o)
  );

  cve2_sat_counter #(
    .Width(StatsWidth)
  ) u_sleep_entries (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (sleep_entry),
    .clr_i (stats_clr_i),
    .cnt_o (sleep_entries_o)
  );
`else
  logic unused_stats_width;
  assign unused_stats_width = (StatsWidth != 0);
`endif

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Bench for cve2_sleep_ctrl: hold=3 and hold=0 instances vs a run-length model.
// Statistics ports are exercised when CVE2_SLEEP_STATS_EN is defined.
module tb_cve2_sleep_ctrl;

  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          fe = 1'b0;
  logic          busy = 1'b0;
  logic          dbg = 1'b0;
  logic          nmi = 1'b0;
  logic          irqp = 1'b0;
  logic          clr = 1'b0;
  logic [NW-1:0] wk = '0;
  logic [NW-1:0] msk = '0;

  logic fe_o [2];
  logic ce_o [2];
  logic sl_o [2];

`ifdef CVE2_SLEEP_STATS_EN
  logic [31:0] cyc0, ent0;
  logic [2:0]  cyc1, ent1;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cve2_sleep_ctrl #(
    .NumWakeSrc(NW), .IdleHoldCycles(3), .StatsWidth(32)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .fetch_enable_i(fe), .core_busy_i(busy),
    .debug_req_i(dbg), .irq_nm_i(nmi), .irq_pending_i(irqp),
    .wake_i(wk), .wake_mask_i(msk),
    .fetch_enable_o(fe_o[0]), .clock_en_o(ce_o[0]),
    .core_sleep_o(sl_o[0])
`ifdef CVE2_SLEEP_STATS_EN
    , .stats_clr_i(clr)
    , .sleep_cycles_o(cyc0)
    , .sleep_entries_o(ent0)
`endif
  );

  cve2_sleep_ctrl #(
    .NumWakeSrc(NW), .IdleHoldCycles(0), .StatsWidth(3)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni),
    .fetch_enable_i(fe), .core_busy_i(busy),
    .debug_req_i(dbg), .irq_nm_i(nmi), .irq_pending_i(irqp),
    .wake_i(wk), .wake_mask_i(msk),
    .fetch_enable_o(fe_o[1]), .clock_en_o(ce_o[1]),
    .core_sleep_o(sl_o[1])
`ifdef CVE2_SLEEP_STATS_EN
    , .stats_clr_i(clr)
    , .sleep_cycles_o(cyc1)
    , .sleep_entries_o(ent1)
`endif
  );

  // Model: started flag, sleeping flag, length of the current idle run
  int     hold [2] = '{3, 0};
  longint smax [2] = '{64'hFFFF_FFFF, 64'd7};
  bit     m_on [2];
  bit     m_slp [2];
  int     m_run [2];
  longint m_cyc [2];
  longint m_ent [2];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit wake_m();
    return dbg | nmi | irqp | (|(wk & msk));
  endfunction

  function automatic longint sat_inc(longint v, longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_on[d] = 0; m_slp[d] = 0; m_run[d] = 0;
      m_cyc[d] = 0; m_ent[d] = 0;
    end
  endtask

  task automatic model_edge();
    bit w, idle, asleep, entered;
    w = wake_m();
    idle = !busy && !w;
    for (int d = 0; d < 2; d++) begin
      asleep  = m_on[d] && m_slp[d] && !w;
      entered = 0;
      if (!m_on[d]) begin
        if (fe) m_on[d] = 1;
      end else if (m_slp[d]) begin
        if (w) m_slp[d] = 0;
      end else if (idle) begin
        m_run[d]++;
        if (m_run[d] == hold[d] + 1) begin
          m_slp[d] = 1; m_run[d] = 0; entered = 1;
        end
      end else begin
        m_run[d] = 0;
      end
`ifdef CVE2_SLEEP_STATS_EN
      if (clr) begin
        m_cyc[d] = 0; m_ent[d] = 0;
      end else begin
        if (asleep) m_cyc[d] = sat_inc(m_cyc[d], smax[d]);
        if (entered) m_ent[d] = sat_inc(m_ent[d], smax[d]);
      end
`else
      if (asleep && entered) m_cyc[d] = 0;
`endif
    end
  endtask

  task automatic check_all();
    bit w;
    w = wake_m();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("fe%0d", d), fe_o[d], m_on[d]);
      check($sformatf("ce%0d", d), ce_o[d],
            m_on[d] && (!m_slp[d] || w));
      check($sformatf("sl%0d", d), sl_o[d],
            m_on[d] && m_slp[d] && !w);
    end
`ifdef CVE2_SLEEP_STATS_EN
    check("cyc0", cyc0, m_cyc[0]);
    check("ent0", ent0, m_ent[0]);
    check("cyc1", cyc1, m_cyc[1]);
    check("ent1", ent1, m_ent[1]);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("rst_fe", fe_o[0], 1'b0);
    check("rst_ce", ce_o[0], 1'b0);
    check("rst_sl", sl_o[0], 1'b0);
    check_all();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic go_sleep();
    busy = 0;
    repeat (4) tick();
  endtask

  task automatic nmi_wake();
    nmi = 1;
    tick();
    nmi = 0;
    busy = 1;
    tick();
  endtask

  initial begin
    int p_busy;
    do_reset();

    fe = 1; busy = 1;
    tick();
    fe = 0;
    check("fe_latch", fe_o[0], 1'b1);
    check("ce_run", ce_o[0], 1'b1);
    repeat (2) tick();
    check("fe_sticky", fe_o[0], 1'b1);
    check("ce_sticky", ce_o[0], 1'b1);

    busy = 0;
    repeat (3) tick();
    check("hold3_ce", ce_o[0], 1'b1);
    tick();
    check("hold4_ce", ce_o[0], 1'b0);
    check("hold4_sleep", sl_o[0], 1'b1);

    nmi_wake();
    busy = 0;
    repeat (2) tick();
    busy = 1;
    tick();
    busy = 0;
    repeat (3) tick();
    check("rearm_ce", ce_o[0], 1'b1);
    tick();
    check("rearm_sleep", sl_o[0], 1'b1);

    wk = 4'b0100; msk = 4'b1011;
    #1;
    check("masked_ce", ce_o[0], 1'b0);
    check("masked_sl", sl_o[0], 1'b1);
    tick();
    msk = 4'b1111;
    #1;
    check("unmask_ce", ce_o[0], 1'b1);
    check("unmask_sl", sl_o[0], 1'b0);
    tick();
    wk = '0; busy = 1;
    #1;
    check("unmask_run", ce_o[0], 1'b1);
    tick();

    go_sleep();
    nmi = 1;
    #1;
    check("nmi_ce", ce_o[0], 1'b1);
    tick();
    nmi = 0;
    check("nmi_run_ce", ce_o[0], 1'b1);
    check("nmi_run_sl", sl_o[0], 1'b0);
    dbg = 1;
    repeat (6) tick();
    check("dbg_run", ce_o[0], 1'b1);
    dbg = 0; busy = 1;
    tick();

`ifdef CVE2_SLEEP_STATS_EN
    clr = 1;
    tick();
    clr = 0;
    foreach (hold[e]) begin
      go_sleep();
      repeat ((e == 0) ? 5 : 7) tick();
      nmi_wake();
    end
    check("st_entries", ent0, 32'd2);
    check("st_cycles", cyc0, 32'd12);
    check("st_sat", cyc1, 3'd7);
    go_sleep();
    tick();
    clr = 1;
    tick();
    clr = 0;
    check("clr_cyc0", cyc0, 32'd0);
    check("clr_ent0", ent0, 32'd0);
    check("clr_cyc1", cyc1, 3'd0);
    nmi_wake();
`endif

    p_busy = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 32 == 0) begin
        case ($urandom_range(0, 2))
          0: p_busy = 5;
          1: p_busy = 50;
          default: p_busy = 95;
        endcase
        msk = NW'($urandom);
      end
      busy = ($urandom_range(0, 99) < p_busy);
      fe   = ($urandom_range(0, 99) < 15);
      dbg  = ($urandom_range(0, 99) < 2);
      nmi  = ($urandom_range(0, 99) < 2);
      irqp = ($urandom_range(0, 99) < 2);
      for (int j = 0; j < NW; j++) wk[j] = ($urandom_range(0, 99) < 4);
`ifdef CVE2_SLEEP_STATS_EN
      clr = ($urandom_range(0, 99) < 2);
`endif
      if ($urandom_range(0, 999) < 4) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
